// File: rtl/alarm_clock_pkg.sv
// Shared types, limits and time helpers for the multi-channel alarm clock.
// Optional build macro ALARM_SNOOZE_EN enables the snooze path in alarm_channel.
package alarm_clock_pkg;

    typedef struct packed {
        logic [7:0] hh;
        logic [7:0] mm;
        logic [7:0] ss;
    } time_t;

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZE   = 2'd3
    } chan_state_e;

    localparam logic [7:0] MAX_HH = 8'd23;
    localparam logic [7:0] MAX_MM = 8'd59;
    localparam logic [7:0] MAX_SS = 8'd59;

    function automatic logic time_valid(input time_t t);
        return (t.hh <= MAX_HH) && (t.mm <= MAX_MM) && (t.ss <= MAX_SS);
    endfunction

    // One-second increment with minute/hour carries and midnight wrap.
    function automatic time_t time_inc(input time_t t);
        time_t r;
        r = t;
        if (t.ss == MAX_SS) begin
            r.ss = 8'd0;
            if (t.mm == MAX_MM) begin
                r.mm = 8'd0;
                if (t.hh == MAX_HH) begin
                    r.hh = 8'd0;
                end else begin
                    r.hh = t.hh + 8'd1;
                end
            end else begin
                r.mm = t.mm + 8'd1;
            end
        end else begin
            r.ss = t.ss + 8'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One alarm channel: stored alarm time, match comparator, ring FSM with timeout.
// Snooze state and countdown exist only when ALARM_SNOOZE_EN is defined.
module alarm_channel
    import alarm_clock_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  tick_i,
    input  time_t next_time_i,
    input  logic  wr_i,
    input  logic  wr_en_i,
    input  time_t wr_time_i,
    input  logic  ack_i,
    input  logic  snooze_i,
    output logic  ring_o
);

    localparam int RW = (RING_SECS > 1) ? $clog2(RING_SECS) : 1;
    localparam logic [RW-1:0] RING_TC = RW'((RING_SECS > 0) ? RING_SECS - 1 : 0);

    chan_state_e   state_q;
    time_t         alm_q;
    logic [RW-1:0] ring_cnt_q;
    logic          ring_q;
    logic          match_s;
    logic          ring_done_s;

    // The comparison is against the time being loaded on this tick edge.
    assign match_s     = tick_i && (next_time_i == alm_q);
    assign ring_done_s = (RING_SECS != 0) && (ring_cnt_q == RING_TC);

`ifdef ALARM_SNOOZE_EN
    localparam int SW = (SNOOZE_SECS > 1) ? $clog2(SNOOZE_SECS + 1) : 1;
    localparam logic [SW-1:0] SNZ_LOAD = SW'(SNOOZE_SECS);

    logic [SW-1:0] snz_cnt_q;
`else
    logic unused_snooze_s;
    assign unused_snooze_s = snooze_i | (SNOOZE_SECS == 0);
`endif

    // Channel FSM; ring_q is updated alongside the state so it equals (state == RINGING).
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DISARMED;
            alm_q      <= '0;
            ring_cnt_q <= '0;
            ring_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else if (wr_i) begin
            alm_q      <= wr_time_i;
            state_q    <= wr_en_i ? ARMED : DISARMED;
            ring_cnt_q <= '0;
            ring_q     <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snz_cnt_q  <= '0;
`endif
        end else begin
            case (state_q)
                ARMED: begin
                    if (match_s) begin
                        state_q    <= RINGING;
                        ring_cnt_q <= '0;
                        ring_q     <= 1'b1;
                    end
                end
                RINGING: begin
                    if (ack_i) begin
                        state_q <= ARMED;
                        ring_q  <= 1'b0;
                    end
`ifdef ALARM_SNOOZE_EN
                    else if (snooze_i) begin
                        state_q   <= SNOOZE;
                        snz_cnt_q <= SNZ_LOAD;
                        ring_q    <= 1'b0;
                    end
`endif
                    else if (tick_i) begin
                        if (ring_done_s) begin
                            state_q <= ARMED;
                            ring_q  <= 1'b0;
                        end else begin
                            ring_cnt_q <= ring_cnt_q + RW'(1);
                        end
                    end
                end
`ifdef ALARM_SNOOZE_EN
                SNOOZE: begin
                    if (ack_i) begin
                        state_q <= ARMED;
                    end else if (tick_i) begin
                        if (snz_cnt_q <= SW'(1)) begin
                            state_q    <= RINGING;
                            ring_cnt_q <= '0;
                            ring_q     <= 1'b1;
                        end else begin
                            snz_cnt_q <= snz_cnt_q - SW'(1);
                        end
                    end
                end
`endif
                default: begin
                    state_q <= state_q;
                    ring_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ring_o = ring_q;

endmodule

// File: rtl/alarm_clock_multi.sv
// 24h time-of-day counter with seconds prescaler and NUM_ALARMS alarm channels.
// Build macro ALARM_SNOOZE_EN adds per-channel snooze (see alarm_channel).
module alarm_clock_multi
    import alarm_clock_pkg::*;
#(
    parameter int TICK_DIV    = 1,
    parameter int NUM_ALARMS  = 4,
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  set_valid,
    input  logic [7:0]            set_hh,
    input  logic [7:0]            set_mm,
    input  logic [7:0]            set_ss,
    input  logic                  alm_wr,
    input  logic [3:0]            alm_idx,
    input  logic                  alm_en,
    input  logic [7:0]            alm_hh,
    input  logic [7:0]            alm_mm,
    input  logic [7:0]            alm_ss,
    input  logic [NUM_ALARMS-1:0] ack,
    input  logic [NUM_ALARMS-1:0] snooze,
    output logic [7:0]            hours,
    output logic [7:0]            minutes,
    output logic [7:0]            seconds,
    output logic                  sec_tick,
    output logic                  set_err,
    output logic [NUM_ALARMS-1:0] ring,
    output logic                  alarm
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(TICK_DIV - 1);

    logic [PW-1:0]         pre_q;
    logic [PW-1:0]         pre_d;
    time_t                 time_q;
    time_t                 time_d;
    time_t                 next_time_s;
    time_t                 set_time_s;
    time_t                 alm_time_s;
    logic                  set_ok_s;
    logic                  set_bad_s;
    logic                  idx_ok_s;
    logic                  alm_ok_s;
    logic                  alm_bad_s;
    logic                  tick_s;
    logic                  sec_tick_q;
    logic                  set_err_q;
    logic [NUM_ALARMS-1:0] wr_s;
    logic [NUM_ALARMS-1:0] ring_s;

    // Set/write validation, prescaler and time next-state; a valid set suppresses the tick.
    always_comb begin
        set_time_s  = '{hh: set_hh, mm: set_mm, ss: set_ss};
        alm_time_s  = '{hh: alm_hh, mm: alm_mm, ss: alm_ss};
        set_ok_s    = set_valid && time_valid(set_time_s);
        set_bad_s   = set_valid && !time_valid(set_time_s);
        idx_ok_s    = ({1'b0, alm_idx} < 5'(NUM_ALARMS));
        alm_ok_s    = alm_wr && idx_ok_s && time_valid(alm_time_s);
        alm_bad_s   = alm_wr && idx_ok_s && !time_valid(alm_time_s);
        tick_s      = (pre_q == PRE_TC) && !set_ok_s;
        next_time_s = time_inc(time_q);
        if (set_ok_s) begin
            pre_d  = '0;
            time_d = set_time_s;
        end else if (tick_s) begin
            pre_d  = '0;
            time_d = next_time_s;
        end else begin
            pre_d  = pre_q + PW'(1);
            time_d = time_q;
        end
    end

    // Per-channel write strobes; out-of-range indices decode to nothing.
    always_comb begin
        wr_s = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            wr_s[i] = alm_ok_s && (alm_idx == 4'(i));
        end
    end

    // Time, prescaler and registered pulse outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q      <= '0;
            time_q     <= '0;
            sec_tick_q <= 1'b0;
            set_err_q  <= 1'b0;
        end else begin
            pre_q      <= pre_d;
            time_q     <= time_d;
            sec_tick_q <= tick_s;
            set_err_q  <= set_bad_s || alm_bad_s;
        end
    end

    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_chan
        alarm_channel #(
            .RING_SECS   (RING_SECS),
            .SNOOZE_SECS (SNOOZE_SECS)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .tick_i      (tick_s),
            .next_time_i (next_time_s),
            .wr_i        (wr_s[gi]),
            .wr_en_i     (alm_en),
            .wr_time_i   (alm_time_s),
            .ack_i       (ack[gi]),
            .snooze_i    (snooze[gi]),
            .ring_o      (ring_s[gi])
        );
    end

    assign hours    = time_q.hh;
    assign minutes  = time_q.mm;
    assign seconds  = time_q.ss;
    assign sec_tick = sec_tick_q;
    assign set_err  = set_err_q;
    assign ring     = ring_s;
    assign alarm    = |ring_s;

endmodule

// File: tb/tb_alarm_clock_multi.sv
// Self-checking bench for alarm_clock_multi (TICK_DIV=4, 4 channels, RING_SECS=3, SNOOZE_SECS=2).
// Expectations for the snooze sequence follow ALARM_SNOOZE_EN.
module tb_alarm_clock_multi;

    localparam int TD = 4;
    localparam int NA = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          set_valid = 1'b0;
    logic [7:0]    set_hh = 8'd0, set_mm = 8'd0, set_ss = 8'd0;
    logic          alm_wr = 1'b0;
    logic [3:0]    alm_idx = 4'd0;
    logic          alm_en = 1'b0;
    logic [7:0]    alm_hh = 8'd0, alm_mm = 8'd0, alm_ss = 8'd0;
    logic [NA-1:0] ack = '0;
    logic [NA-1:0] snooze = '0;
    logic [7:0]    hours, minutes, seconds;
    logic          sec_tick, set_err, alarm;
    logic [NA-1:0] ring;

    always #5 clk = ~clk;

    alarm_clock_multi #(
        .TICK_DIV(TD), .NUM_ALARMS(NA), .RING_SECS(3), .SNOOZE_SECS(2)
    ) dut (
        .clk(clk), .reset(reset), .set_valid(set_valid),
        .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
        .alm_wr(alm_wr), .alm_idx(alm_idx), .alm_en(alm_en),
        .alm_hh(alm_hh), .alm_mm(alm_mm), .alm_ss(alm_ss),
        .ack(ack), .snooze(snooze),
        .hours(hours), .minutes(minutes), .seconds(seconds),
        .sec_tick(sec_tick), .set_err(set_err), .ring(ring), .alarm(alarm)
    );

    typedef struct {
        string         nm;
        logic [7:0]    hh, mm, ss;
        logic [NA-1:0] rg;
        logic          al, tk, er;
    } exp_t;

    typedef struct {
        string      nm;
        logic       sv;
        logic [7:0] h, m, s;
        logic       aw;
        logic [3:0] idx;
        logic [7:0] a_h, a_m, a_s;
        logic       err;
    } vec_t;

    exp_t          sb[$];
    vec_t          vt[6];
    int            n_chk = 0;
    int            n_pass = 0;
    int            mt = 0;
    int            ph = 0;
    logic [NA-1:0] exp_ring = '0;
    logic          exp_err = 1'b0;
`ifdef ALARM_SNOOZE_EN
    localparam bit SNZ = 1'b1;
`else
    localparam bit SNZ = 1'b0;
`endif

    function automatic bit in_rng(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        return (h <= 8'd23) && (m <= 8'd59) && (s <= 8'd59);
    endfunction

    // Push the expected post-edge outputs, clock once, then pop and compare.
    task automatic step(input string nm);
        exp_t e;
        logic tk;
        tk = 1'b0;
        if (reset) begin
            mt = 0;
            ph = 0;
        end else if (set_valid && in_rng(set_hh, set_mm, set_ss)) begin
            mt = int'(set_hh) * 3600 + int'(set_mm) * 60 + int'(set_ss);
            ph = 0;
        end else if (ph == TD - 1) begin
            ph = 0;
            mt = (mt + 1) % 86400;
            tk = 1'b1;
        end else begin
            ph = ph + 1;
        end
        e.nm = nm;
        e.hh = 8'(mt / 3600);
        e.mm = 8'((mt / 60) % 60);
        e.ss = 8'(mt % 60);
        e.rg = reset ? '0 : exp_ring;
        e.al = |e.rg;
        e.tk = tk;
        e.er = reset ? 1'b0 : exp_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        n_chk++;
        if (hours === e.hh && minutes === e.mm && seconds === e.ss && ring === e.rg &&
            alarm === e.al && sec_tick === e.tk && set_err === e.er) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d:%0d:%0d ring=%b alarm=%b tick=%b err=%b, want %0d:%0d:%0d ring=%b alarm=%b tick=%b err=%b",
                     e.nm, hours, minutes, seconds, ring, alarm, sec_tick, set_err,
                     e.hh, e.mm, e.ss, e.rg, e.al, e.tk, e.er);
        end
    endtask

    task automatic check_val(input string nm, input int act, input int want);
        n_chk++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d want %0d", nm, act, want);
    endtask

    task automatic do_set(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s, input logic err);
        set_valid = 1'b1; set_hh = h; set_mm = m; set_ss = s; exp_err = err;
        step("set");
        set_valid = 1'b0; exp_err = 1'b0;
    endtask

    task automatic wr_alarm(input logic [3:0] idx, input logic en, input logic [7:0] h,
                            input logic [7:0] m, input logic [7:0] s, input logic err);
        alm_wr = 1'b1; alm_idx = idx; alm_en = en; alm_hh = h; alm_mm = m; alm_ss = s; exp_err = err;
        step("alm_wr");
        alm_wr = 1'b0; exp_err = 1'b0;
    endtask

    initial begin
        vt[0] = '{"set_hh24",  1'b1, 8'd24, 8'd0,  8'd0,  1'b0, 4'd0, 8'd0, 8'd0,  8'd0, 1'b1};
        vt[1] = '{"set_mm60",  1'b1, 8'd12, 8'd60, 8'd0,  1'b0, 4'd0, 8'd0, 8'd0,  8'd0, 1'b1};
        vt[2] = '{"set_ss60",  1'b1, 8'd12, 8'd0,  8'd60, 1'b0, 4'd0, 8'd0, 8'd0,  8'd0, 1'b1};
        vt[3] = '{"alm_mm60",  1'b0, 8'd0,  8'd0,  8'd0,  1'b1, 4'd1, 8'd0, 8'd60, 8'd0, 1'b1};
        vt[4] = '{"alm_idx7",  1'b0, 8'd0,  8'd0,  8'd0,  1'b1, 4'd7, 8'd0, 8'd0,  8'd2, 1'b0};
        vt[5] = '{"alm_idx9b", 1'b0, 8'd0,  8'd0,  8'd0,  1'b1, 4'd9, 8'd0, 8'd99, 8'd0, 1'b0};

        reset = 1'b1;
        step("reset0");
        step("reset1");
        reset = 1'b0;

        // Wrap through midnight with a tick every 4th clock.
        do_set(8'd23, 8'd59, 8'd58, 1'b0);
        for (int k = 0; k < 8; k++) step("wrap");
        check_val("wrap_hh", hours, 0);
        check_val("wrap_mm", minutes, 0);
        check_val("wrap_ss", seconds, 0);

        // Set coinciding with a terminal count: load wins, no tick.
        for (int k = 0; k < 3; k++) step("pre_set");
        do_set(8'd10, 8'd0, 8'd0, 1'b0);

        for (int v = 0; v < 6; v++) begin
            set_valid = vt[v].sv; set_hh = vt[v].h; set_mm = vt[v].m; set_ss = vt[v].s;
            alm_wr = vt[v].aw; alm_idx = vt[v].idx; alm_en = 1'b1;
            alm_hh = vt[v].a_h; alm_mm = vt[v].a_m; alm_ss = vt[v].a_s;
            exp_err = vt[v].err;
            step(vt[v].nm);
            set_valid = 1'b0; alm_wr = 1'b0; exp_err = 1'b0;
        end

        // Match on ch2 after a rejected rewrite of it; then ack.
        wr_alarm(4'd2, 1'b1, 8'd0, 8'd0, 8'd5, 1'b0);
        wr_alarm(4'd2, 1'b1, 8'd0, 8'd60, 8'd5, 1'b1);
        do_set(8'd0, 8'd0, 8'd3, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            exp_ring = (k == 8) ? 4'b0100 : 4'b0000;
            step("match");
        end
        check_val("match_ss", seconds, 5);
        ack = 4'b0100; exp_ring = 4'b0000;
        step("ack2");
        ack = 4'b0000;

        // Timeout: ch0 drops on the 3rd tick after it starts ringing.
        wr_alarm(4'd0, 1'b1, 8'd0, 8'd0, 8'd10, 1'b0);
        do_set(8'd0, 8'd0, 8'd8, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            exp_ring = (k >= 8 && k < 20) ? 4'b0001 : 4'b0000;
            step("timeout");
        end

        // Snooze on ch1.
        wr_alarm(4'd1, 1'b1, 8'd0, 8'd0, 8'd20, 1'b0);
        do_set(8'd0, 8'd0, 8'd19, 1'b0);
        for (int k = 1; k <= 13; k++) begin
            snooze = (k == 5) ? 4'b0010 : 4'b0000;
            ack    = (k == 13) ? 4'b0010 : 4'b0000;
            if (k < 4 || k == 13) exp_ring = 4'b0000;
            else if (k >= 5 && k <= 11 && SNZ) exp_ring = 4'b0000;
            else exp_ring = 4'b0010;
            step("snooze");
        end
        snooze = 4'b0000; ack = 4'b0000; exp_ring = 4'b0000;

        // Reset while two channels ring, then confirm channels are disarmed.
        wr_alarm(4'd0, 1'b1, 8'd0, 8'd0, 8'd30, 1'b0);
        wr_alarm(4'd2, 1'b1, 8'd0, 8'd0, 8'd30, 1'b0);
        do_set(8'd0, 8'd0, 8'd29, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            exp_ring = (k == 4) ? 4'b0101 : 4'b0000;
            step("pre_reset");
        end
        reset = 1'b1; exp_ring = 4'b0000;
        step("mid_reset");
        reset = 1'b0;
        do_set(8'd23, 8'd59, 8'd59, 1'b0);
        for (int k = 0; k < 4; k++) step("disarm_mid");
        do_set(8'd0, 8'd0, 8'd29, 1'b0);
        for (int k = 0; k < 4; k++) step("disarm_30");

        // Set to exactly the alarm time never triggers; approaching it does.
        wr_alarm(4'd3, 1'b1, 8'd1, 8'd2, 8'd3, 1'b0);
        do_set(8'd1, 8'd2, 8'd3, 1'b0);
        for (int k = 0; k < 4; k++) step("set_match");
        do_set(8'd1, 8'd2, 8'd2, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            exp_ring = (k == 4) ? 4'b1000 : 4'b0000;
            step("ch3_ring");
        end
        exp_ring = 4'b0000;
        wr_alarm(4'd3, 1'b0, 8'd1, 8'd2, 8'd3, 1'b0);
        for (int k = 0; k < 4; k++) step("ch3_off");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
